// File: rtl/ascii_hex_serializer_pkg.sv
// Shared constants, terminator mode codes and FSM state encoding for the
// hex-to-ASCII serializer.
package ascii_hex_serializer_pkg;

    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_UA = 8'h41;
    localparam logic [7:0] ASCII_LA = 8'h61;
    localparam logic [7:0] ASCII_X  = 8'h78;
    localparam logic [7:0] ASCII_SP = 8'h20;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    localparam int TERM_NONE  = 0;
    localparam int TERM_SPACE = 1;
    localparam int TERM_CRLF  = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PREFIX0 = 3'd1,
        ST_PREFIX1 = 3'd2,
        ST_DIGITS  = 3'd3,
        ST_TERM0   = 3'd4,
        ST_TERM1   = 3'd5
    } state_t;

    function automatic logic [7:0] hex_char(input logic [3:0] n, input bit lower);
        if (n < 4'd10)
            return ASCII_0 + {4'h0, n};
        else
            return (lower ? ASCII_LA : ASCII_UA) + {4'h0, n} - 8'd10;
    endfunction

endpackage

// File: rtl/nibble_to_ascii.sv
// Combinational 4-bit value to ASCII hex digit.
module nibble_to_ascii
    import ascii_hex_serializer_pkg::*;
#(
    parameter bit LOWERCASE = 1'b0
) (
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    assign ascii = hex_char(nibble, LOWERCASE);

endmodule

// File: rtl/ascii_hex_serializer.sv
// Accepts one binary word and streams its hex text one ASCII byte per output
// handshake, MS digit first, with optional "0x" prefix and terminator.
module ascii_hex_serializer
    import ascii_hex_serializer_pkg::*;
#(
    parameter int NBR_OF_NIBBLES = 4,
    parameter bit LOWERCASE      = 1'b0,
    parameter bit PREFIX_EN      = 1'b0,
    parameter int TERMINATOR     = 0
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NBR_OF_NIBBLES*4-1:0] in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [7:0]                  out_char,
    output logic                        out_valid,
    input  logic                        out_ready
);

    localparam int IW = (NBR_OF_NIBBLES > 1) ? $clog2(NBR_OF_NIBBLES) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(NBR_OF_NIBBLES - 1);
    localparam logic [7:0] TERM0_CHAR = (TERMINATOR == TERM_SPACE) ? ASCII_SP : ASCII_CR;

    state_t                      state;
    logic [IW-1:0]               idx;
    logic [NBR_OF_NIBBLES*4-1:0] shadow;

    logic [NBR_OF_NIBBLES*4-1:0] word;
    logic [IW-1:0]               nib_idx;
    logic [3:0]                  nib;
    logic [7:0]                  dig_char;
    logic                        hs;

    assign in_ready = (state == ST_IDLE) && reset_n;
    assign hs       = out_valid && out_ready;

    // The digit mux looks one character ahead: it presents the digit that the
    // output register will load on the coming edge. While idle the shadow is
    // not yet loaded, so the first digit comes straight from in_data.
    assign word = (state == ST_IDLE) ? in_data : shadow;

    always_comb begin
        nib_idx = IDX_LAST;
        if (state == ST_DIGITS)
            nib_idx = idx - 1'b1;
    end

    always_comb begin
        nib = 4'h0;
        for (int i = 0; i < NBR_OF_NIBBLES; i++)
            if (nib_idx == IW'(i))
                nib = word[4*i +: 4];
    end

    nibble_to_ascii #(.LOWERCASE(LOWERCASE)) u_n2a (
        .nibble (nib),
        .ascii  (dig_char)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            idx       <= '0;
            shadow    <= '0;
            out_char  <= 8'h00;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        shadow    <= in_data;
                        idx       <= IDX_LAST;
                        out_valid <= 1'b1;
                        if (PREFIX_EN) begin
                            state    <= ST_PREFIX0;
                            out_char <= ASCII_0;
                        end else begin
                            state    <= ST_DIGITS;
                            out_char <= dig_char;
                        end
                    end
                end
                ST_PREFIX0: begin
                    if (hs) begin
                        state    <= ST_PREFIX1;
                        out_char <= ASCII_X;
                    end
                end
                ST_PREFIX1: begin
                    if (hs) begin
                        state    <= ST_DIGITS;
                        out_char <= dig_char;
                    end
                end
                ST_DIGITS: begin
                    if (hs) begin
                        if (idx != '0) begin
                            idx      <= idx - 1'b1;
                            out_char <= dig_char;
                        end else if (TERMINATOR != TERM_NONE) begin
                            state    <= ST_TERM0;
                            out_char <= TERM0_CHAR;
                        end else begin
                            state     <= ST_IDLE;
                            out_valid <= 1'b0;
                        end
                    end
                end
                ST_TERM0: begin
                    if (hs) begin
                        if (TERMINATOR == TERM_CRLF) begin
                            state    <= ST_TERM1;
                            out_char <= ASCII_LF;
                        end else begin
                            state     <= ST_IDLE;
                            out_valid <= 1'b0;
                        end
                    end
                end
                ST_TERM1: begin
                    if (hs) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ascii_hex_serializer.sv
// Four serializer configurations on a shared stimulus bus, checked against
// per-instance expected-character queues.
module tb_ascii_hex_serializer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] din = 16'h0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [3:0]  ir, ov;
    logic [7:0]  oc [4];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // A: upper, "0x", CRLF   B: lower, bare   C: upper, bare   D: 1 nibble, space
    ascii_hex_serializer #(.NBR_OF_NIBBLES(4), .LOWERCASE(1'b0), .PREFIX_EN(1'b1), .TERMINATOR(2)) u_a (
        .clk(clk), .reset_n(reset_n), .in_data(din), .in_valid(in_valid), .in_ready(ir[0]),
        .out_char(oc[0]), .out_valid(ov[0]), .out_ready(out_ready));
    ascii_hex_serializer #(.NBR_OF_NIBBLES(4), .LOWERCASE(1'b1), .PREFIX_EN(1'b0), .TERMINATOR(0)) u_b (
        .clk(clk), .reset_n(reset_n), .in_data(din), .in_valid(in_valid), .in_ready(ir[1]),
        .out_char(oc[1]), .out_valid(ov[1]), .out_ready(out_ready));
    ascii_hex_serializer #(.NBR_OF_NIBBLES(4), .LOWERCASE(1'b0), .PREFIX_EN(1'b0), .TERMINATOR(0)) u_c (
        .clk(clk), .reset_n(reset_n), .in_data(din), .in_valid(in_valid), .in_ready(ir[2]),
        .out_char(oc[2]), .out_valid(ov[2]), .out_ready(out_ready));
    ascii_hex_serializer #(.NBR_OF_NIBBLES(1), .LOWERCASE(1'b0), .PREFIX_EN(1'b0), .TERMINATOR(1)) u_d (
        .clk(clk), .reset_n(reset_n), .in_data(din[3:0]), .in_valid(in_valid), .in_ready(ir[3]),
        .out_char(oc[3]), .out_valid(ov[3]), .out_ready(out_ready));

    typedef struct {
        logic [15:0] data;
        string       ea;
        string       eb;
        string       ec;
        string       ed;
    } vec_t;

    vec_t vecs [4];
    logic [7:0] sbq [4][$];

    function automatic string exp_of(input int vi, input int k);
        case (k)
            0:       return vecs[vi].ea;
            1:       return vecs[vi].eb;
            2:       return vecs[vi].ec;
            default: return vecs[vi].ed;
        endcase
    endfunction

    function automatic bit all_empty();
        return sbq[0].size() == 0 && sbq[1].size() == 0 &&
               sbq[2].size() == 0 && sbq[3].size() == 0;
    endfunction

    // Output monitor: pops on every handshake, and checks hold-while-stalled.
    logic [3:0] pv = '0;
    logic [7:0] pc [4];
    logic       pr = 1'b1;
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (reset_n && pv[k] && !pr) begin
                checks++;
                if (!(ov[k] && oc[k] == pc[k])) begin
                    errors++;
                    $display("FAIL stall_hold inst%0d: valid=%0b char=%h, required valid=1 char=%h", k, ov[k], oc[k], pc[k]);
                end
            end
            if (reset_n && ov[k] && out_ready) begin
                checks++;
                if (sbq[k].size() == 0) begin
                    errors++;
                    $display("FAIL extra_char inst%0d: got char=%h, required no character", k, oc[k]);
                end else begin
                    logic [7:0] e;
                    e = sbq[k].pop_front();
                    if (oc[k] !== e) begin
                        errors++;
                        $display("FAIL char inst%0d: got %h, required %h", k, oc[k], e);
                    end
                end
            end
            pv[k] = reset_n && ov[k];
            pc[k] = oc[k];
        end
        pr = out_ready;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (ir == 4'hF && all_empty()) return;
        end
        checks++;
        errors++;
        $display("FAIL idle_timeout: in_ready=%b, required 1111", ir);
    endtask

    // Returns just after the accepting edge (+#1).
    task automatic start(input int vi);
        wait_idle();
        @(posedge clk); #1;
        din      = vecs[vi].data;
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            string s;
            s = exp_of(vi, k);
            for (int i = 0; i < s.len(); i++) sbq[k].push_back(s[i]);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input bit bp, input bit timing, input int vi);
        int cyc;
        bit done;
        string s;
        cyc  = 0;
        done = 1'b0;
        s    = vecs[vi].ea;
        while (!done && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (timing) begin
                if (cyc <= 8) begin
                    check($sformatf("lat_valid_c%0d", cyc), {31'd0, ov[0]}, 32'd1);
                    check($sformatf("lat_char_c%0d", cyc), {24'd0, oc[0]}, {24'd0, s[cyc-1]});
                end
                if (cyc == 8) check("busy_last_char", {31'd0, ir[0]}, 32'd0);
                if (cyc == 9) check("ready_after_word", {31'd0, ir[0]}, 32'd1);
            end
            if (bp && cyc <= 3) check($sformatf("busy_ignore_c%0d", cyc), {28'd0, ir}, 32'd0);
            if (ir == 4'hF && all_empty() && cyc >= 2) begin
                done = 1'b1;
            end else begin
                @(posedge clk); #1;
                in_valid = bp && cyc < 3;
                if (bp && cyc < 3) din = 16'hDEAD;
                out_ready = bp ? ((cyc < 3) ? 1'b0 : 1'($urandom_range(0, 1))) : 1'b1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: in_ready=%b, pending=%0d/%0d/%0d/%0d, required all done",
                     ir, sbq[0].size(), sbq[1].size(), sbq[2].size(), sbq[3].size());
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        vecs[0] = '{16'hBEEF, "0xBEEF\015\012", "beef", "BEEF", "F "};
        vecs[1] = '{16'h09AF, "0x09AF\015\012", "09af", "09AF", "F "};
        vecs[2] = '{16'h1234, "0x1234\015\012", "1234", "1234", "4 "};
        vecs[3] = '{16'h0009, "0x0009\015\012", "0009", "0009", "9 "};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", {28'd0, ir}, 32'd0);
        check("rst_out_valid", {28'd0, ov}, 32'd0);
        for (int k = 0; k < 4; k++) check($sformatf("rst_out_char%0d", k), {24'd0, oc[k]}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_release_ready", {28'd0, ir}, 32'hF);

        // Full-rate words, with exact latency/timing on the first
        start(0); drain(1'b0, 1'b1, 0);
        start(1); drain(1'b0, 1'b0, 1);
        start(3); drain(1'b0, 1'b0, 3);

        // Back-pressure with busy-time in_valid and in_data changes
        wait_idle();
        out_ready = 1'b0;
        start(2); drain(1'b1, 1'b0, 2);

        // Reset in the middle of a word
        start(0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b0;
        for (int k = 0; k < 4; k++) sbq[k].delete();
        @(posedge clk); #1;
        @(negedge clk);
        check("midrst_out_valid", {28'd0, ov}, 32'd0);
        check("midrst_in_ready", {28'd0, ir}, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("midrst_ready_after", {28'd0, ir}, 32'hF);
        check("midrst_valid_after", {28'd0, ov}, 32'd0);
        start(1); drain(1'b0, 1'b0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
